// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: widths, the canonical NOP and fetch FSM states.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    HOLD
  } fetch_state_t;

  // Force an address onto a word boundary.
  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register holding one instruction slot: valid, instruction word, PC and PC+4.
// Clear invalidates the slot (instruction becomes NOP) but keeps the PC fields.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic [XLEN-1:0] nxt_instr,
  input  logic [XLEN-1:0] nxt_pc,
  input  logic [XLEN-1:0] nxt_pcplus4,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcplus4
);

  // Slot update: clear beats load, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      instr   <= NOP_INSTR;
      pc      <= '0;
      pcplus4 <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (en) begin
      valid   <= 1'b1;
      instr   <= nxt_instr;
      pc      <= nxt_pc;
      pcplus4 <= nxt_pcplus4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the fetch PC, keeps one request outstanding on the
// instruction memory port, buffers one word across decode stalls and writes IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            redirect_e,
  input  logic [XLEN-1:0] redirect_pc_e,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d,
  output logic            valid_d
);

  import riscv_pkg::*;

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc_f, pc_f_nxt;
  logic [XLEN-1:0] hold_instr, hold_instr_nxt;
  logic            kill, kill_nxt;
  // Set by reset until the first handshake: a response to a request issued before
  // reset may still straggle in and is silently ignored.
  logic            late_rsp_ok, late_rsp_ok_nxt;
  logic            load;
  logic [XLEN-1:0] load_instr;
  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4        = pc_f + XLEN'(4);
  assign late_rsp_ok_nxt = late_rsp_ok && !(imem_req && imem_ready);

  // Fetch state, PC, kill flag and stall buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ISSUE;
      pc_f        <= RESET_PC;
      hold_instr  <= '0;
      kill        <= 1'b0;
      late_rsp_ok <= 1'b1;
    end else begin
      state       <= state_nxt;
      pc_f        <= pc_f_nxt;
      hold_instr  <= hold_instr_nxt;
      kill        <= kill_nxt;
      late_rsp_ok <= late_rsp_ok_nxt;
    end
  end

  // Next-state, memory request and IF/ID load decisions; redirect overrides everything.
  always_comb begin
    state_nxt      = state;
    pc_f_nxt       = pc_f;
    hold_instr_nxt = hold_instr;
    kill_nxt       = kill;
    imem_req       = 1'b0;
    imem_addr      = pc_f;
    load           = 1'b0;
    load_instr     = imem_rdata;

    if (redirect_e) begin
      pc_f_nxt = align4(redirect_pc_e);
      if (state == WAIT && !imem_rvalid) begin
        // Response still in flight: remember to drop it when it lands.
        kill_nxt = 1'b1;
      end else begin
        kill_nxt  = 1'b0;
        state_nxt = ISSUE;
      end
    end else begin
      unique case (state)
        ISSUE: begin
          imem_req = 1'b1;
          if (imem_ready) state_nxt = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (kill) begin
              kill_nxt  = 1'b0;
              state_nxt = ISSUE;
            end else if (!stall_d) begin
              load      = 1'b1;
              pc_f_nxt  = pc_plus4;
              // Back-to-back: request the following word in the same cycle.
              imem_req  = 1'b1;
              imem_addr = pc_plus4;
              state_nxt = imem_ready ? WAIT : ISSUE;
            end else begin
              hold_instr_nxt = imem_rdata;
              state_nxt      = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_d) begin
            load       = 1'b1;
            load_instr = hold_instr;
            pc_f_nxt   = pc_plus4;
            state_nxt  = ISSUE;
          end
        end
        default: state_nxt = ISSUE;
      endcase
    end

    if (!rst_n) imem_req = 1'b0;
  end

  if_id_reg u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (load),
    .clr        (flush_d),
    .nxt_instr  (load_instr),
    .nxt_pc     (pc_f),
    .nxt_pcplus4(pc_plus4),
    .valid      (valid_d),
    .instr      (instr_d),
    .pc         (pc_d),
    .pcplus4    (pcplus4_d)
  );

  a_flush_needs_redirect: assert property (
    @(posedge clk) disable iff (!rst_n) flush_d |-> redirect_e);

  a_rvalid_only_in_wait: assert property (
    @(posedge clk) disable iff (!rst_n) (imem_rvalid && !late_rsp_ok) |-> (state == WAIT));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory responder, expected-PC stream model and scoreboard monitor.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_d;
  logic        flush_d;
  logic        redirect_e;
  logic [31:0] redirect_pc_e;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;

  int checks    = 0;
  int passed    = 0;
  int delivered = 0;
  int mem_lat   = 1;
  bit pend      = 1'b0;

  // Expected stream of PCs decode should see, in order.
  logic [31:0] exp_q[$];
  logic [31:0] exp_nxt;

  fetch_stage #(
    .RESET_PC(RESET_PC),
    .XLEN    (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .redirect_e   (redirect_e),
    .redirect_pc_e(redirect_pc_e),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .pcplus4_d    (pcplus4_d),
    .valid_d      (valid_d)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back(exp_nxt);
      exp_nxt = exp_nxt + 32'd4;
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    exp_nxt = RESET_PC;
    refill();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    redirect_e = 1'b0;
    flush_d    = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    redirect_e    = 1'b1;
    flush_d       = 1'b1;
    redirect_pc_e = t;
    exp_q.delete();
    exp_nxt = t & ~32'd3;
    refill();
  endtask

  // Wait (bounded) for a request handshake; optionally check its address.
  task automatic wait_hs(input string name, input bit chk, input logic [31:0] exp_a);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (imem_req && imem_ready) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      $display("FAIL %s: no handshake within 30 cycles, expected addr %08h", name, exp_a);
    end else if (chk) begin
      check(name, imem_addr, exp_a);
    end
  endtask

  // Keep the expected stream topped up.
  initial forever begin
    @(posedge clk);
    refill();
  end

  // Memory: one outstanding request, response mem_lat cycles after the handshake.
  initial begin : memory
    bit          hs;
    int          cnt;
    logic [31:0] a, pa;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    cnt = 0;
    pa  = 32'h0;
    forever begin
      @(negedge clk);
      hs = rst_n && imem_req && imem_ready;
      a  = imem_addr;
      if (hs) begin
        check("one_outstanding", {31'b0, pend}, 32'd0);
        check("addr_align", {30'b0, a[1:0]}, 32'd0);
      end
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (hs) begin
        pend = 1'b1;
        cnt  = mem_lat;
        pa   = a;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend        = 1'b0;
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pa);
        end
      end
    end
  end

  // Scoreboard monitor: each newly presented, non-flushed IF/ID entry is checked.
  initial begin : monitor
    bit          pv;
    logic [31:0] pp, e;
    pv = 1'b0;
    pp = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (valid_d && (!pv || pc_d != pp) && !flush_d) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL sb_empty: got pc %08h with no expectation", pc_d);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc", pc_d, e);
            check("sb_instr", instr_d, mem_word(e));
            check("sb_pcplus4", pcplus4_d, e + 32'd4);
            delivered++;
          end
        end
        pv = valid_d;
        pp = pc_d;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish, %0d/%0d", passed, checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] rec_pc, rec_instr, a_rec;
    int          d0;
    bit          seen;
    logic [31:0] t;

    rst_n         = 1'b0;
    imem_ready    = 1'b1;
    stall_d       = 1'b0;
    flush_d       = 1'b0;
    redirect_e    = 1'b0;
    redirect_pc_e = 32'h0;
    reset_model();

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, valid_d}, 32'd0);
    check("rst_instr", instr_d, 32'h0000_0013);
    check("rst_pc", pc_d, 32'h0);
    check("rst_pcplus4", pcplus4_d, 32'h0);

    // Release at edge 0; first valid after edge 2, then one per cycle
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("lat_edge1_valid", {31'b0, valid_d}, 32'd0);
    @(negedge clk);
    check("lat_edge2_valid", {31'b0, valid_d}, 32'd1);
    check("lat_edge2_pc", pc_d, RESET_PC);
    tick();
    d0 = delivered;
    repeat (8) tick();
    check("throughput_8", 32'(delivered - d0), 32'd8);

    // Stall for 3 cycles while a response arrives
    tick();
    stall_d = 1'b1;
    @(negedge clk);
    rec_pc    = pc_d;
    rec_instr = instr_d;
    repeat (2) begin
      tick();
      @(negedge clk);
      check("stall_hold_pc", pc_d, rec_pc);
      check("stall_hold_instr", instr_d, rec_instr);
    end
    tick();
    stall_d = 1'b0;
    @(negedge clk);
    check("stall_release_hold", pc_d, rec_pc);
    tick();
    @(negedge clk);
    check("stall_buffered_pc", pc_d, rec_pc + 32'd4);
    check("stall_buffered_valid", {31'b0, valid_d}, 32'd1);

    // Memory not ready for 4 cycles
    tick();
    imem_ready = 1'b0;
    @(negedge clk);
    check("notready_req", {31'b0, imem_req}, 32'd1);
    a_rec = imem_addr;
    repeat (3) begin
      tick();
      @(negedge clk);
      check("notready_req", {31'b0, imem_req}, 32'd1);
      check("notready_addr", imem_addr, a_rec);
    end
    tick();
    imem_ready = 1'b1;
    repeat (4) tick();

    // Redirect+flush in WAIT, stale response two cycles later
    mem_lat = 2;
    tick();
    tick();
    wait_hs("t4_hs", 1'b0, 32'h0);
    tick();
    redirect_to(32'h0000_0103);
    @(negedge clk);
    check("t4_req_forced_low", {31'b0, imem_req}, 32'd0);
    tick();
    @(negedge clk);
    check("t4_flush_valid", {31'b0, valid_d}, 32'd0);
    check("t4_flush_instr", instr_d, 32'h0000_0013);
    wait_hs("t4_refetch_addr", 1'b1, 32'h0000_0100);
    repeat (4) tick();

    // Redirect coinciding with rvalid, target at the top of the address space
    tick();
    mem_lat = 1;
    tick();
    tick();
    wait_hs("t5_hs", 1'b0, 32'h0);
    tick();
    check("t5_rvalid_coincident", {31'b0, imem_rvalid}, 32'd1);
    redirect_to(32'hFFFF_FFFC);
    @(negedge clk);
    check("t5_req_forced_low", {31'b0, imem_req}, 32'd0);
    tick();
    wait_hs("t5_fetch_top", 1'b1, 32'hFFFF_FFFC);
    wait_hs("t5_fetch_wrap", 1'b1, 32'h0000_0000);
    @(negedge clk);
    check("t5_pc_top", pc_d, 32'hFFFF_FFFC);
    check("t5_pcplus4_wrap", pcplus4_d, 32'h0);
    repeat (4) tick();

    // Reset in the middle of WAIT; late response must be ignored
    mem_lat = 3;
    tick();
    tick();
    wait_hs("t6_hs", 1'b0, 32'h0);
    @(posedge clk);
    #1;
    imem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_req", {31'b0, imem_req}, 32'd0);
    check("t6_rst_valid", {31'b0, valid_d}, 32'd0);
    check("t6_rst_instr", instr_d, 32'h0000_0013);
    check("t6_rst_pc", pc_d, 32'h0);
    check("t6_rst_pcplus4", pcplus4_d, 32'h0);
    reset_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (imem_rvalid) seen = 1'b1;
    end
    check("t6_late_rvalid_seen", {31'b0, seen}, 32'd1);
    check("t6_no_valid_yet", {31'b0, valid_d}, 32'd0);
    tick();
    imem_ready = 1'b1;
    mem_lat    = 1;
    wait_hs("t6_restart_addr", 1'b1, RESET_PC);
    repeat (6) tick();

    // Randomised traffic against the stream model
    d0 = delivered;
    for (int i = 0; i < 2000; i++) begin
      tick();
      stall_d    = ($urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mem_lat = $urandom_range(1, 3);
      if ($urandom_range(0, 39) == 0) begin
        t = $urandom;
        if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
        redirect_to(t);
      end
    end
    tick();
    stall_d    = 1'b0;
    imem_ready = 1'b1;
    repeat (10) tick();
    check("random_progress", {31'b0, (delivered - d0) >= 200}, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the RV32I 5-stage pipeline, directly upstream of decode. It owns the fetch PC, drives a request/response instruction-memory port with one outstanding request, and writes the IF/ID pipeline register. The decode controller slices opcode, funct3 and funct7[5] from that register. It also handles decode stalls, execute-stage redirects (branch/jump) and IF/ID flushes.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset.
XLEN, 32, address/data width. Only 32 is supported.

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address; bits [1:0] always 0
imem_ready  in  1  memory accepts request this cycle (req && ready = handshake)
imem_rvalid  in  1  response valid; at least 1 cycle after its handshake
imem_rdata  in  32  instruction word
stall_d  in  1  decode cannot accept; hold IF/ID
flush_d  in  1  invalidate IF/ID; only legal with redirect_e=1
redirect_e  in  1  execute-stage PC redirect
redirect_pc_e  in  32  redirect target; bits [1:0] ignored (treated as 0)
instr_d  out  32  IF/ID instruction
pc_d  out  32  IF/ID PC
pcplus4_d  out  32  IF/ID PC+4
valid_d  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, immediate):
  - pc_f=RESET_PC, state=ISSUE, kill=0, buffer empty.
  - valid_d=0, instr_d=32'h0000_0013 (NOP), pc_d=0, pcplus4_d=0.
  - imem_req=0 while rst_n=0.
- States:
  - ISSUE: request pending.
  - WAIT: request outstanding.
  - HOLD: response captured in the 1-entry buffer while decode is stalled.
- ISSUE:
  - Drive imem_req=1, imem_addr=pc_f; go to WAIT on handshake.
  - If ready=0, stay in ISSUE with req and addr stable.
- WAIT, on imem_rvalid:
  - If kill or redirect_e: discard the word, clear kill, go to ISSUE.
  - Else if !stall_d: load IF/ID {rdata, pc_f, pc_f+4} with valid_d=1, and set pc_f+=4.
    - Back-to-back: in the same cycle drive imem_req=1, imem_addr=pc_f+4.
    - On handshake stay in WAIT, otherwise go to ISSUE.
  - Else (stall_d=1): capture rdata into the buffer, go to HOLD.
- HOLD:
  - When stall_d=0: move the buffer into IF/ID (pc_d=pc_f), set pc_f+=4, go to ISSUE.
- Redirect (highest priority, any state):
  - pc_f <= {redirect_pc_e[31:2], 2'b00}.
  - imem_req forced to 0 that cycle.
  - In ISSUE/HOLD: drop the buffer, go to ISSUE.
  - In WAIT without rvalid: set kill, stay in WAIT; the stale response is discarded when it arrives.
- IF/ID register priority: flush_d > load > stall_d hold.
  - flush_d sets valid_d=0, instr_d=NOP; pc_d and pcplus4_d hold.
- Arithmetic: PC+4 is modulo 2^32 (0xFFFF_FFFC+4 = 0).
- Latency: reset release at edge 0, single-cycle memory → valid_d first high after edge 2. Steady state is 1 instruction per cycle.
- imem_rvalid in ISSUE or HOLD is a protocol error (assertion). After reset, any late rvalid is ignored.
- flush_d without redirect_e: assertion fires.

Decomposition:
- Shared package riscv_pkg:
  - XLEN.
  - NOP_INSTR = 32'h0000_0013.
  - fetch_state_t enum {ISSUE, WAIT, HOLD}.
- One sub-module if_id_reg: async-reset register with en, clr, and valid/instr/pc/pcplus4 fields. It is reusable for later pipeline registers.

Test Plan:
1. Reset with RESET_PC=0, imem_ready=1, 1-cycle memory, word at addr A = A>>2 → from edge 2, one instruction per cycle: instr_d 0,1,2…, pc_d 0,4,8…, pcplus4_d = pc_d+4.
2. stall_d=1 for 3 cycles while a response arrives → IF/ID unchanged; the buffered word reaches IF/ID the cycle after stall_d drops; no loss, no duplicate.
3. imem_ready=0 for 4 cycles → imem_req=1 and imem_addr stable throughout; fetch resumes correctly.
4. redirect_e+flush_d with redirect_pc_e=0x103 in WAIT, response 2 cycles later:
   - valid_d=0 and instr_d=0x13 next cycle.
   - The stale word is discarded.
   - Next imem_addr=0x100, then instr_d=mem[0x100].
5. Redirect coinciding with rvalid, and redirect to 0xFFFF_FFFC:
   - The coincident word is dropped.
   - pc_d=0xFFFF_FFFC, pcplus4_d=0, next fetch at 0.
6. rst_n low mid-WAIT → all outputs take reset values immediately; a late rvalid after release is ignored; fetch restarts at RESET_PC.
